// File: rtl/ps2_key_decoder.sv
// PS/2 Set-2 receiver: conditions the pins, frames bytes and turns make/break
// sequences for Space, Left and Right into held key levels.
module ps2_key_decoder #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT_US = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_space,
  output logic       key_left,
  output logic       key_right,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int unsigned TimeoutCyc = CLK_FREQ / 1_000_000 * TIMEOUT_US;
  localparam int unsigned WdW        = $clog2(TimeoutCyc + 1);
  localparam int unsigned FltW       = $clog2(FILTER_LEN + 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  logic            clk_s1, clk_s2, data_s1, data_s2;
  logic            clk_f, clk_f_q, fall;
  logic [FltW-1:0] filt_cnt;
  state_e          state;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            par;
  logic [WdW-1:0]  wd;
  logic            ext, brk;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
      clk_f    <= 1'b1;
      clk_f_q  <= 1'b1;
      filt_cnt <= '0;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
      clk_f_q <= clk_f;
      // Only a run of FILTER_LEN samples disagreeing with clk_f moves it.
      if (clk_s2 != clk_f) begin
        if (filt_cnt == FltW'(FILTER_LEN - 1)) begin
          clk_f    <= clk_s2;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + FltW'(1);
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  assign fall = clk_f_q & ~clk_f;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= StIdle;
      bit_cnt    <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      wd         <= '0;
      scan_code  <= '0;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (state != StIdle && !fall && wd >= WdW'(TimeoutCyc)) begin
        state     <= StIdle;
        frame_err <= 1'b1;
        wd        <= '0;
      end else begin
        if (state == StIdle || fall) wd <= '0;
        else                         wd <= wd + WdW'(1);
        if (fall) begin
          case (state)
            StIdle: begin
              if (!data_s2) begin
                state   <= StData;
                bit_cnt <= '0;
              end else begin
                frame_err <= 1'b1;
              end
            end
            StData: begin
              shreg   <= {data_s2, shreg[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= StParity;
            end
            StParity: begin
              par   <= data_s2;
              state <= StStop;
            end
            StStop: begin
              if (data_s2 && (^{shreg, par})) begin
                scan_code  <= shreg;
                code_valid <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
              state <= StIdle;
            end
            default: state <= StIdle;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext       <= 1'b0;
      brk       <= 1'b0;
      key_space <= 1'b0;
      key_left  <= 1'b0;
      key_right <= 1'b0;
    end else if (code_valid) begin
      if (scan_code == 8'hE0) begin
        ext <= 1'b1;
      end else if (scan_code == 8'hF0) begin
        brk <= 1'b1;
      end else begin
        if (!ext && scan_code == 8'h29) key_space <= !brk;
        if (ext && scan_code == 8'h6B)  key_left  <= !brk;
        if (ext && scan_code == 8'h74)  key_right <= !brk;
        ext <= 1'b0;
        brk <= 1'b0;
      end
    end else if (frame_err) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end
  end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Receives PS/2 keyboard frames and decodes Set-2 make/break sequences into held key levels: key_space, key_left, key_right.
- Sits between the board PS/2 pins and the character movement controller; its key outputs connect directly to that controller's key inputs.
- Also exposes the raw scan-code stream and a frame-error pulse for debug and ILA.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- FILTER_LEN, 8, number of consecutive equal synchronized ps2_clk samples required before the filtered clock changes.
- TIMEOUT_US, 2000, maximum allowed gap between ps2_clk falling edges inside a frame, in µs. TIMEOUT_CYC = CLK_FREQ/1_000_000*TIMEOUT_US = 200_000 at the defaults.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  reset, asynchronous, active-low.
- ps2_clk  in  1  PS/2 clock pin, asynchronous to clk.
- ps2_data  in  1  PS/2 data pin, asynchronous to clk.
- key_space  out  1  level, 1 while Space (0x29) is held.
- key_left  out  1  level, 1 while Left arrow (E0 6B) is held.
- key_right  out  1  level, 1 while Right arrow (E0 74) is held.
- scan_code  out  8  last valid received byte.
- code_valid  out  1  one-cycle pulse, scan_code updated.
- frame_err  out  1  one-cycle pulse on parity, start, stop or timeout error.

Behaviour:
- Reset (rst=0, asynchronous): all outputs, flags, counters and the FSM clear to 0/IDLE. Filter and synchronizer state initialise to 1 (line idle). Applies mid-frame and discards the partial frame.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-FF synchronizer.
  - Filtered clock clk_f changes only after FILTER_LEN consecutive equal synchronized samples.
  - fall = clk_f registered 1→0. Data is sampled from synchronized ps2_data on the cycle fall is asserted.
- Frame FSM (advances only on fall, except timeout):
  - IDLE: bit=0 → DATA with bit_cnt=0. Bit=1 → frame_err, stay IDLE.
  - DATA: shift in LSB first; after 8 bits → PARITY.
  - PARITY: store bit → STOP.
  - STOP: require stop=1 and odd parity over the 8 data bits plus the parity bit. Both good → scan_code, code_valid. Otherwise → frame_err, scan_code unchanged. Always return to IDLE.
  - Timeout: in DATA, PARITY or STOP, a gap of more than TIMEOUT_CYC cycles since the last fall → IDLE plus frame_err. The watchdog counter resets on every fall and is held at 0 in IDLE.
- Latency: code_valid/scan_code are asserted on the cycle after the stop-bit fall is detected; key outputs update on the following cycle (fall + 2).
- Decode (acts on code_valid):
  - 0xE0 → ext=1.
  - 0xF0 → brk=1.
  - Any other byte: (ext=0, 0x29) → key_space = !brk; (ext=1, 0x6B) → key_left = !brk; (ext=1, 0x74) → key_right = !brk; all other bytes leave keys unchanged. Then clear ext and brk.
  - frame_err clears ext and brk; key levels are kept.
- Boundary rules:
  - Typematic repeat makes (repeated 29) keep key_space=1 with no toggling.
  - Left and right may both be 1; this block does no arbitration.
  - Non-extended 0x74/0x6B (keypad 6/4) must NOT set the arrow keys.
  - Extended 0x29 must NOT set key_space.
  - A second E0 or F0 before the final byte simply keeps its flag set.
  - A clk_f pulse shorter than FILTER_LEN cycles produces no fall.

Test Plan:
- Send Space make frame 0x29 (odd parity bit 0), ~12.5 kHz PS/2 clock → code_valid with scan_code=0x29, then key_space=1 two cycles after the stop fall; other keys stay 0.
- Send E0 74, later E0 F0 74 → key_right goes 1 after the 74 byte, returns to 0 after the final 74 of the break sequence; key_left and key_space stay 0 throughout.
- Hold left and right (E0 6B, E0 74), then send 0x6B alone → key_left=1 and key_right=1; the plain 6B changes nothing; scan_code=0x6B.
- Frame 0x29 with flipped parity → frame_err pulse, no code_valid, key_space unchanged. Then a good F0 29 → key_space=0.
- Stop ps2_clk after 4 data bits, with TIMEOUT_US reduced to 10 (1000 cycles) → frame_err at gap 1001, FSM back in IDLE, next full frame decodes correctly.
- Assert rst low mid-frame with key_space=1 → all outputs 0 immediately (asynchronous); after release, a fresh 0x29 frame sets key_space=1. A 3-cycle glitch on ps2_clk produces no data shift.
